// File: rtl/tlul_pkg.sv
// TL-UL bus field widths, packed channel structs and the opcodes used on them.
package tlul_pkg;

    localparam int TL_AW  = 32;
    localparam int TL_DW  = 32;
    localparam int TL_AIW = 8;
    localparam int TL_DIW = 1;
    localparam int TL_DUW = 16;
    localparam int TL_SZW = 2;
    localparam int TL_DBW = TL_DW / 8;

    // valid + opcode + param + size + source + address + mask + data + user + d_ready
    localparam int TL_H2D_W = 1 + 3 + 3 + TL_SZW + TL_AIW + TL_AW + TL_DBW + TL_DW + TL_DUW + 1;
    // valid + opcode + param + size + source + sink + data + user + error + a_ready
    localparam int TL_D2H_W = 1 + 3 + 3 + TL_SZW + TL_AIW + TL_DIW + TL_DW + TL_DUW + 1 + 1;

    // Payload of a beat: everything between the leading valid and the trailing ready.
    localparam int TL_A_PL_W = TL_H2D_W - 2;
    localparam int TL_D_PL_W = TL_D2H_W - 2;

    typedef enum logic [2:0] {
        PutFullData    = 3'd0,
        PutPartialData = 3'd1,
        Get            = 3'd4
    } tl_a_op_e;

    typedef enum logic [2:0] {
        AccessAck     = 3'd0,
        AccessAckData = 3'd1
    } tl_d_op_e;

    typedef struct packed {
        logic              a_valid;
        logic [2:0]        a_opcode;
        logic [2:0]        a_param;
        logic [TL_SZW-1:0] a_size;
        logic [TL_AIW-1:0] a_source;
        logic [TL_AW-1:0]  a_address;
        logic [TL_DBW-1:0] a_mask;
        logic [TL_DW-1:0]  a_data;
        logic [TL_DUW-1:0] a_user;
        logic              d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic              d_valid;
        logic [2:0]        d_opcode;
        logic [2:0]        d_param;
        logic [TL_SZW-1:0] d_size;
        logic [TL_AIW-1:0] d_source;
        logic [TL_DIW-1:0] d_sink;
        logic [TL_DW-1:0]  d_data;
        logic [TL_DUW-1:0] d_user;
        logic              d_error;
        logic              a_ready;
    } tl_d2h_t;

endpackage

// File: rtl/tlul_fifo_os_buf.sv
// Generic valid/ready synchronous FIFO with optional empty-bypass and occupancy output.
module tlul_fifo_os_buf #(
    parameter int unsigned  Width  = 8,
    parameter int unsigned  Depth  = 2,
    parameter bit           Pass   = 1'b1,
    localparam int unsigned DepthW = $clog2(Depth + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              wvalid_i,
    output logic              wready_o,
    input  logic [Width-1:0]  wdata_i,
    output logic              rvalid_o,
    input  logic              rready_i,
    output logic [Width-1:0]  rdata_o,
    output logic [DepthW-1:0] depth_o
);

    localparam int unsigned       PtrW     = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [PtrW-1:0]   LastPtr  = PtrW'(Depth - 1);
    localparam logic [DepthW-1:0] FullCnt  = DepthW'(Depth);

    logic [Width-1:0]  mem [Depth];
    logic [PtrW-1:0]   wr_ptr;
    logic [PtrW-1:0]   rd_ptr;
    logic [DepthW-1:0] count;

    logic empty;
    logic full;
    logic bypass;
    logic wr_fire;
    logic rd_fire;
    logic push;
    logic pop;

    // Handshake: a full FIFO still takes a write when the read side drains in the same cycle.
    always_comb begin
        // NOTE: every signal here is assigned on every path, so no latch can be inferred.
        empty    = (count == '0);
        full     = (count == FullCnt);
        bypass   = Pass && empty;
        rvalid_o = bypass ? wvalid_i : !empty;
        rdata_o  = bypass ? wdata_i : mem[rd_ptr];
        wready_o = !full || rready_i;
        wr_fire  = wvalid_i && wready_o;
        rd_fire  = rvalid_o && rready_i;
        // A bypassed beat that is consumed immediately never occupies an entry.
        push     = wr_fire && !(bypass && rd_fire);
        pop      = rd_fire && !bypass;
    end

    // Pointer and occupancy state; pointers wrap at Depth so odd depths work.
    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == LastPtr) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LastPtr) ? '0 : rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage.
    always_ff @(posedge clk_i) begin
        // NOTE: storage is not reset; count gates every read, so stale contents are never visible.
        if (push) begin
            mem[wr_ptr] <= wdata_i;
        end
    end

    assign depth_o = count;

endmodule

// File: rtl/tlul_fifo_sync_os.sv
// TL-UL host/device decoupling FIFO pair with outstanding limit, quiesce, idle and error reporting.
module tlul_fifo_sync_os
    import tlul_pkg::*;
#(
    parameter bit          ReqPass        = 1'b1,
    parameter bit          RspPass        = 1'b1,
    parameter int unsigned ReqDepth       = 2,
    parameter int unsigned RspDepth       = 2,
    parameter int unsigned MaxOutstanding = 4,
    parameter int unsigned SpareReqW      = 1,
    parameter int unsigned SpareRspW      = 1
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  tl_h2d_t                           tl_h_i,
    output tl_d2h_t                           tl_h_o,
    output tl_h2d_t                           tl_d_o,
    input  tl_d2h_t                           tl_d_i,
    input  logic [SpareReqW-1:0]              spare_req_i,
    output logic [SpareReqW-1:0]              spare_req_o,
    input  logic [SpareRspW-1:0]              spare_rsp_i,
    output logic [SpareRspW-1:0]              spare_rsp_o,
    input  logic                              quiesce_i,
    output logic [$clog2(ReqDepth+1)-1:0]     req_depth_o,
    output logic [$clog2(RspDepth+1)-1:0]     rsp_depth_o,
    output logic [7:0]                        os_cnt_o,
    output logic                              idle_o,
    output logic                              err_unexp_rsp_o
);

    localparam int unsigned ReqW   = TL_A_PL_W + SpareReqW;
    localparam int unsigned RspW   = TL_D_PL_W + SpareRspW;
    localparam logic [7:0]  MaxOs  = 8'(MaxOutstanding);

    logic            out_en;
    logic [7:0]      os_cnt;
    logic [7:0]      dev_os;
    logic            err_unexp;

    logic            req_wvalid;
    logic            req_wready;
    logic            req_rvalid;
    logic            req_rready;
    logic [ReqW-1:0] req_rdata;

    logic            rsp_wvalid;
    logic            rsp_wready;
    logic            rsp_rvalid;
    logic            rsp_rready;
    logic [RspW-1:0] rsp_rdata;

    logic            host_a_ready;
    logic            host_d_valid;
    logic            dev_a_valid;
    logic            dev_d_ready;
    logic            host_a_acc;
    logic            host_d_acc;
    logic            dev_a_acc;
    logic            dev_d_acc;

    // Holds every port handshake low while in reset and for the first cycle after it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_en <= 1'b0;
        end else begin
            out_en <= 1'b1;
        end
    end

    // Port gating and accept strobes; a response taken by the host this cycle frees a slot at once.
    always_comb begin
        host_d_valid = rsp_rvalid && out_en;
        host_d_acc   = host_d_valid && tl_h_i.d_ready;
        host_a_ready = out_en && req_wready && !quiesce_i && ((os_cnt < MaxOs) || host_d_acc);
        host_a_acc   = tl_h_i.a_valid && host_a_ready;
        dev_a_valid  = req_rvalid && out_en;
        dev_a_acc    = dev_a_valid && tl_d_i.a_ready;
        dev_d_ready  = rsp_wready && out_en;
        dev_d_acc    = tl_d_i.d_valid && dev_d_ready;
        req_wvalid   = host_a_acc;
        req_rready   = tl_d_i.a_ready && out_en;
        rsp_wvalid   = tl_d_i.d_valid && out_en;
        rsp_rready   = tl_h_i.d_ready && out_en;
    end

    tlul_fifo_os_buf #(
        .Width (ReqW),
        .Depth (ReqDepth),
        .Pass  (ReqPass)
    ) u_req_fifo (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .wvalid_i (req_wvalid),
        .wready_o (req_wready),
        .wdata_i  ({spare_req_i, tl_h_i[TL_H2D_W-2:1]}),
        .rvalid_o (req_rvalid),
        .rready_i (req_rready),
        .rdata_o  (req_rdata),
        .depth_o  (req_depth_o)
    );

    tlul_fifo_os_buf #(
        .Width (RspW),
        .Depth (RspDepth),
        .Pass  (RspPass)
    ) u_rsp_fifo (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .wvalid_i (rsp_wvalid),
        .wready_o (rsp_wready),
        .wdata_i  ({spare_rsp_i, tl_d_i[TL_D2H_W-2:1]}),
        .rvalid_o (rsp_rvalid),
        .rready_i (rsp_rready),
        .rdata_o  (rsp_rdata),
        .depth_o  (rsp_depth_o)
    );

    // Host-side outstanding count; a stray response never drives it below zero.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            os_cnt <= '0;
        end else begin
            case ({host_a_acc, host_d_acc})
                2'b10:   os_cnt <= os_cnt + 1'b1;
                2'b01:   os_cnt <= (os_cnt != '0) ? os_cnt - 1'b1 : os_cnt;
                2'b11:   os_cnt <= (os_cnt != '0) ? os_cnt : 8'd1;
                default: os_cnt <= os_cnt;
            endcase
        end
    end

    // Device-side outstanding count and sticky flag for responses nobody asked for.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            dev_os    <= '0;
            err_unexp <= 1'b0;
        end else begin
            if (dev_d_acc && (dev_os == '0)) begin
                err_unexp <= 1'b1;
            end
            case ({dev_a_acc, dev_d_acc})
                2'b10:   dev_os <= dev_os + 1'b1;
                2'b01:   dev_os <= (dev_os != '0) ? dev_os - 1'b1 : dev_os;
                2'b11:   dev_os <= (dev_os != '0) ? dev_os : 8'd1;
                default: dev_os <= dev_os;
            endcase
        end
    end

    assign tl_d_o          = {dev_a_valid, req_rdata[TL_A_PL_W-1:0], dev_d_ready};
    assign tl_h_o          = {host_d_valid, rsp_rdata[TL_D_PL_W-1:0], host_a_ready};
    assign spare_req_o     = req_rdata[ReqW-1 -: SpareReqW];
    assign spare_rsp_o     = rsp_rdata[RspW-1 -: SpareRspW];
    assign os_cnt_o        = os_cnt;
    assign err_unexp_rsp_o = err_unexp;
    assign idle_o          = (os_cnt == '0) && (dev_os == '0) &&
                             (req_depth_o == '0) && (rsp_depth_o == '0);

endmodule

// File: tb/tb_tlul_fifo_sync_os.sv
// Scoreboard bench: instance A (no pass, limit 2) for latency and limit checks,
// instance B (pass, limit 4) for bypass, full, quiesce, error and reset checks.
module tb_tlul_fifo_sync_os;
    import tlul_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    tl_h2d_t ha_i, da_o, hb_i, db_o;
    tl_d2h_t ha_o, da_i, hb_o, db_i;
    logic    spq_a_i, spq_a_o, sps_a_i, sps_a_o, quiesce_a;
    logic    spq_b_i, spq_b_o, sps_b_i, sps_b_o, quiesce_b;
    logic [1:0] reqd_a, rspd_a, reqd_b, rspd_b;
    logic [7:0] os_a, os_b;
    logic    idle_a, idle_b, err_a, err_b;

    logic [TL_A_PL_W:0] req_q[$];
    logic [TL_D_PL_W:0] rsp_q[$];

    tlul_fifo_sync_os #(
        .ReqPass(1'b0), .RspPass(1'b0), .ReqDepth(2), .RspDepth(2),
        .MaxOutstanding(2), .SpareReqW(1), .SpareRspW(1)
    ) dut_a (
        .clk_i(clk), .rst_i(rst), .tl_h_i(ha_i), .tl_h_o(ha_o), .tl_d_o(da_o), .tl_d_i(da_i),
        .spare_req_i(spq_a_i), .spare_req_o(spq_a_o), .spare_rsp_i(sps_a_i), .spare_rsp_o(sps_a_o),
        .quiesce_i(quiesce_a), .req_depth_o(reqd_a), .rsp_depth_o(rspd_a), .os_cnt_o(os_a),
        .idle_o(idle_a), .err_unexp_rsp_o(err_a)
    );

    tlul_fifo_sync_os #(
        .ReqPass(1'b1), .RspPass(1'b1), .ReqDepth(2), .RspDepth(2),
        .MaxOutstanding(4), .SpareReqW(1), .SpareRspW(1)
    ) dut_b (
        .clk_i(clk), .rst_i(rst), .tl_h_i(hb_i), .tl_h_o(hb_o), .tl_d_o(db_o), .tl_d_i(db_i),
        .spare_req_i(spq_b_i), .spare_req_o(spq_b_o), .spare_rsp_i(sps_b_i), .spare_rsp_o(sps_b_o),
        .quiesce_i(quiesce_b), .req_depth_o(reqd_b), .rsp_depth_o(rspd_b), .os_cnt_o(os_b),
        .idle_o(idle_b), .err_unexp_rsp_o(err_b)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic tl_h2d_t mk_req(input logic [7:0] src, input logic [31:0] addr,
                                       input logic [31:0] data, input tl_a_op_e op);
        tl_h2d_t r;
        r           = '0;
        r.a_valid   = 1'b1;
        r.a_opcode  = op;
        r.a_size    = 2'd2;
        r.a_source  = src;
        r.a_address = addr;
        r.a_mask    = 4'hf;
        r.a_data    = data;
        r.a_user    = {8'h5a, src};
        r.d_ready   = 1'b1;
        return r;
    endfunction

    function automatic tl_d2h_t mk_rsp(input logic [7:0] src, input logic [31:0] data);
        tl_d2h_t r;
        r          = '0;
        r.d_valid  = 1'b1;
        r.d_opcode = AccessAckData;
        r.d_size   = 2'd2;
        r.d_source = src;
        r.d_data   = data;
        r.d_user   = {8'ha5, src};
        r.a_ready  = 1'b1;
        return r;
    endfunction

    task automatic push_req(input tl_h2d_t r, input logic sp);
        req_q.push_back({sp, r[TL_H2D_W-2:1]});
    endtask

    task automatic push_rsp(input tl_d2h_t r, input logic sp);
        rsp_q.push_back({sp, r[TL_D2H_W-2:1]});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Device-side A monitor for instance B.
    always @(negedge clk) begin
        logic [TL_A_PL_W:0] e;
        if (!rst && db_o.a_valid && db_i.a_ready) begin
            if (req_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL req_sb_extra: beat src %0h with no expected entry", db_o.a_source);
            end else begin
                e = req_q.pop_front();
                check("req_sb", 128'({spq_b_o, db_o[TL_H2D_W-2:1]}), 128'(e));
            end
        end
    end

    // Host-side D monitor for instance B.
    always @(negedge clk) begin
        logic [TL_D_PL_W:0] e;
        if (!rst && hb_o.d_valid && hb_i.d_ready) begin
            if (rsp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rsp_sb_extra: beat src %0h with no expected entry", hb_o.d_source);
            end else begin
                e = rsp_q.pop_front();
                check("rsp_sb", 128'({sps_b_o, hb_o[TL_D2H_W-2:1]}), 128'(e));
            end
        end
    end

    initial begin
        ha_i = '0; da_i = '0; hb_i = '0; db_i = '0;
        spq_a_i = 1'b0; sps_a_i = 1'b0; spq_b_i = 1'b0; sps_b_i = 1'b0;
        quiesce_a = 1'b0; quiesce_b = 1'b0;

        // Reset state, with a live host request on the pass-mode instance.
        hb_i = mk_req(8'h99, 32'h0, 32'h0, Get);
        db_i.a_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_a_ready",   128'(ha_o.a_ready), 128'(0));
        check("rst_dev_d_rdy", 128'(da_o.d_ready), 128'(0));
        check("rst_idle",      128'(idle_a), 128'(1));
        check("rst_depth",     128'({reqd_a, rspd_a, reqd_b}), 128'(0));
        check("rst_b_a_valid", 128'(db_o.a_valid), 128'(0));
        check("rst_b_d_valid", 128'(hb_o.d_valid), 128'(0));
        hb_i = '0;
        db_i = '0;
        rst  = 1'b0;
        tick();

        // Single read on A: request visible one cycle later, response echoes source and data.
        da_i = '0; da_i.a_ready = 1'b1;
        ha_i = mk_req(8'h11, 32'h1000, 32'h0, Get);
        @(negedge clk);
        check("t1_a_ready", 128'(ha_o.a_ready), 128'(1));
        check("t1_no_pass", 128'(da_o.a_valid), 128'(0));
        tick();
        ha_i.a_valid = 1'b0;
        @(negedge clk);
        check("t1_dev_a_valid", 128'(da_o.a_valid), 128'(1));
        check("t1_dev_source",  128'(da_o.a_source), 128'(8'h11));
        check("t1_dev_addr",    128'(da_o.a_address), 128'(32'h1000));
        check("t1_os_1",        128'(os_a), 128'(1));
        tick();
        da_i = mk_rsp(8'h11, 32'hcafe_0011);
        @(negedge clk);
        check("t1_rsp_no_pass", 128'(ha_o.d_valid), 128'(0));
        check("t1_dev_d_ready", 128'(da_o.d_ready), 128'(1));
        tick();
        da_i.d_valid = 1'b0;
        @(negedge clk);
        check("t1_host_d_valid", 128'(ha_o.d_valid), 128'(1));
        check("t1_host_source",  128'(ha_o.d_source), 128'(8'h11));
        check("t1_host_data",    128'(ha_o.d_data), 128'(32'hcafe_0011));
        check("t1_os_still_1",   128'(os_a), 128'(1));
        tick();
        @(negedge clk);
        check("t1_os_0",  128'(os_a), 128'(0));
        check("t1_idle",  128'(idle_a), 128'(1));
        check("t1_err",   128'(err_a), 128'(0));

        // Outstanding limit 2 on A, device silent.
        tick();
        ha_i = mk_req(8'h01, 32'h2000, 32'h0, Get);
        @(negedge clk);
        check("t2_rdy_first", 128'(ha_o.a_ready), 128'(1));
        tick();
        ha_i.a_source = 8'h02; ha_i.a_address = 32'h2004;
        @(negedge clk);
        check("t2_rdy_second", 128'(ha_o.a_ready), 128'(1));
        tick();
        ha_i.a_source = 8'h03;
        @(negedge clk);
        check("t2_rdy_blocked", 128'(ha_o.a_ready), 128'(0));
        check("t2_os_2",        128'(os_a), 128'(2));
        tick();
        ha_i.a_valid = 1'b0;
        da_i = mk_rsp(8'h01, 32'h1);
        tick();
        da_i.d_valid = 1'b0;
        @(negedge clk);
        check("t2_host_d_valid", 128'(ha_o.d_valid), 128'(1));
        check("t2_rdy_same_cyc", 128'(ha_o.a_ready), 128'(1));
        check("t2_os_still_2",   128'(os_a), 128'(2));
        tick();
        @(negedge clk);
        check("t2_os_1",   128'(os_a), 128'(1));
        check("t2_rdy_on", 128'(ha_o.a_ready), 128'(1));
        tick();
        da_i = mk_rsp(8'h02, 32'h2);
        tick();
        da_i.d_valid = 1'b0;
        tick();
        @(negedge clk);
        check("t2_os_0",  128'(os_a), 128'(0));
        check("t2_idle",  128'(idle_a), 128'(1));

        // Pass mode on B: request and response cross the empty FIFOs in the same cycle.
        tick();
        db_i = '0; db_i.a_ready = 1'b1;
        hb_i = mk_req(8'h21, 32'h3000, 32'h1234_5678, PutFullData);
        spq_b_i = 1'b1;
        push_req(hb_i, 1'b1);
        @(negedge clk);
        check("t3_pass_valid", 128'(db_o.a_valid), 128'(1));
        check("t3_pass_data",  128'(db_o.a_data), 128'(32'h1234_5678));
        check("t3_pass_spare", 128'(spq_b_o), 128'(1));
        check("t3_pass_depth", 128'(reqd_b), 128'(0));
        tick();
        hb_i.a_valid = 1'b0; spq_b_i = 1'b0;
        @(negedge clk);
        check("t3_depth_after", 128'(reqd_b), 128'(0));
        tick();
        db_i = mk_rsp(8'h21, 32'h0);
        db_i.d_opcode = AccessAck;
        sps_b_i = 1'b1;
        push_rsp(db_i, 1'b1);
        @(negedge clk);
        check("t3_rsp_pass",  128'(hb_o.d_valid), 128'(1));
        check("t3_rsp_depth", 128'(rspd_b), 128'(0));
        tick();
        db_i.d_valid = 1'b0; sps_b_i = 1'b0;

        // Full request FIFO, then a write and a read in the same cycle.
        db_i.a_ready = 1'b0;
        hb_i = mk_req(8'h31, 32'h4000, 32'h31, PutFullData);
        push_req(hb_i, 1'b0);
        tick();
        hb_i = mk_req(8'h32, 32'h4004, 32'h32, PutFullData);
        push_req(hb_i, 1'b0);
        tick();
        hb_i = mk_req(8'h33, 32'h4008, 32'h33, PutFullData);
        @(negedge clk);
        check("t4_full_depth", 128'(reqd_b), 128'(2));
        check("t4_full_rdy",   128'(hb_o.a_ready), 128'(0));
        tick();
        push_req(hb_i, 1'b0);
        db_i.a_ready = 1'b1;
        @(negedge clk);
        check("t4_rdy_with_read", 128'(hb_o.a_ready), 128'(1));
        tick();
        hb_i.a_valid = 1'b0;
        @(negedge clk);
        check("t4_depth_held", 128'(reqd_b), 128'(2));
        tick();
        tick();
        @(negedge clk);
        check("t4_drained", 128'(reqd_b), 128'(0));
        check("t4_os_3",    128'(os_b), 128'(3));

        // Quiesce with three outstanding, then let the responses drain.
        tick();
        quiesce_b = 1'b1;
        hb_i = mk_req(8'h34, 32'h5000, 32'h0, Get);
        @(negedge clk);
        check("t5_quiesce_rdy", 128'(hb_o.a_ready), 128'(0));
        check("t5_not_idle",    128'(idle_b), 128'(0));
        for (int i = 0; i < 3; i++) begin
            tick();
            db_i = mk_rsp(8'h31 + 8'(i), 32'h100 + 32'(i));
            push_rsp(db_i, 1'b0);
        end
        tick();
        db_i.d_valid = 1'b0;
        @(negedge clk);
        check("t5_os_0",        128'(os_b), 128'(0));
        check("t5_idle",        128'(idle_b), 128'(1));
        check("t5_still_quiet", 128'(hb_o.a_ready), 128'(0));
        check("t5_no_dev_beat", 128'(db_o.a_valid), 128'(0));
        check("t5_no_err",      128'(err_b), 128'(0));
        tick();
        quiesce_b = 1'b0;
        hb_i.a_valid = 1'b0;

        // Unexpected response: forwarded, flag rises next cycle and sticks.
        db_i = mk_rsp(8'h55, 32'hdead_0055);
        push_rsp(db_i, 1'b0);
        @(negedge clk);
        check("t6_err_before", 128'(err_b), 128'(0));
        tick();
        db_i.d_valid = 1'b0;
        @(negedge clk);
        check("t6_err_set", 128'(err_b), 128'(1));
        check("t6_os_0",    128'(os_b), 128'(0));
        repeat (3) tick();
        @(negedge clk);
        check("t6_err_sticky", 128'(err_b), 128'(1));

        // Reset in the middle of a burst.
        tick();
        db_i.a_ready = 1'b0;
        hb_i = mk_req(8'h41, 32'h6000, 32'h41, PutFullData);
        push_req(hb_i, 1'b0);
        tick();
        hb_i = mk_req(8'h42, 32'h6004, 32'h42, PutFullData);
        push_req(hb_i, 1'b0);
        tick();
        hb_i = mk_req(8'h43, 32'h6008, 32'h43, PutFullData);
        @(negedge clk);
        check("t7_pre_depth", 128'(reqd_b), 128'(2));
        check("t7_pre_os",    128'(os_b), 128'(2));
        tick();
        rst = 1'b1;
        req_q.delete();
        rsp_q.delete();
        db_i.a_ready = 1'b1;
        @(negedge clk);
        check("t7_rst_depth", 128'({reqd_b, rspd_b}), 128'(0));
        check("t7_rst_os",    128'(os_b), 128'(0));
        check("t7_rst_valid", 128'({db_o.a_valid, hb_o.d_valid}), 128'(0));
        check("t7_rst_err",   128'(err_b), 128'(0));
        check("t7_rst_idle",  128'(idle_b), 128'(1));
        #1 rst = 1'b0;
        #1;
        check("t7_no_beat_after_rst", 128'(db_o.a_valid), 128'(0));
        check("t7_no_rdy_after_rst",  128'(hb_o.a_ready), 128'(0));
        hb_i.a_valid = 1'b0;
        tick();
        @(negedge clk);
        check("t7_idle_after",  128'(idle_b), 128'(1));
        check("t7_quiet_after", 128'(db_o.a_valid), 128'(0));

        check("sb_req_drained", 128'(req_q.size()), 128'(0));
        check("sb_rsp_drained", 128'(rsp_q.size()), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
